// File: rtl/module_display_arbiter.sv
// Round-robin owner select that shares the 8-digit display path between sources A and B.
// Latency: one clock from request to grant/display. An owner keeps the grant for HOLD_TICKS ticks, then yields to a waiting source.
module module_display_arbiter #(
    parameter int DATA_W     = 32,
    parameter int HOLD_TICKS = 2000,
    parameter int HOLD_BITS  = 11
) (
    input  logic              clk_10Mhz_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic              req_a_i,
    input  logic [DATA_W-1:0] data_a_i,
    input  logic              req_b_i,
    input  logic [DATA_W-1:0] data_b_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic [DATA_W-1:0] display_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(HOLD_TICKS);

    state_t               state_q, state_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic                 ptr_b_q, ptr_b_d;     // 1: B wins the next tie in IDLE
    logic [DATA_W-1:0]    display_q, display_d;
    logic                 gnt_a_q, gnt_a_d;
    logic                 gnt_b_q, gnt_b_d;
    logic                 busy_q, busy_d;
    logic                 expired;

    assign expired = (hold_cnt_q == HOLD_MAX);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_b_d    = ptr_b_q;
        display_d  = display_q;
        case (state_q)
            IDLE: begin
                if (req_a_i && (!req_b_i || !ptr_b_q)) begin
                    state_d    = OWN_A;
                    hold_cnt_d = '0;
                    display_d  = data_a_i;
                end else if (req_b_i) begin
                    state_d    = OWN_B;
                    hold_cnt_d = '0;
                    display_d  = data_b_i;
                end
            end
            OWN_A: begin
                if (!req_a_i) begin
                    // A drop always passes through IDLE; display keeps its last word.
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    ptr_b_d    = 1'b1;
                end else if (expired && req_b_i) begin
                    state_d    = OWN_B;
                    hold_cnt_d = '0;
                    ptr_b_d    = 1'b0;
                    display_d  = data_b_i;
                end else begin
                    display_d = data_a_i;
                    if (tick_i && !expired) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            OWN_B: begin
                if (!req_b_i) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    ptr_b_d    = 1'b0;
                end else if (expired && req_a_i) begin
                    state_d    = OWN_A;
                    hold_cnt_d = '0;
                    ptr_b_d    = 1'b1;
                    display_d  = data_a_i;
                end else begin
                    display_d = data_b_i;
                    if (tick_i && !expired) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        busy_d  = gnt_a_d | gnt_b_d;
    end

    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            ptr_b_q    <= 1'b0;
            display_q  <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_b_q    <= ptr_b_d;
            display_q  <= display_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt_a_o   = gnt_a_q;
    assign gnt_b_o   = gnt_b_q;
    assign display_o = display_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_module_display_arbiter.sv
// Bench for module_display_arbiter: HOLD_TICKS=4, tick every 10 cycles, directed scenarios
// checked against an owner/hold-count model every cycle plus literal expectations.
module tb_module_display_arbiter;

    localparam int DATA_W = 32;
    localparam int HOLD   = 4;
    localparam int HB     = 3;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              tick_i = 1'b0;
    logic              req_a_i = 1'b0;
    logic              req_b_i = 1'b0;
    logic [DATA_W-1:0] data_a_i = '0;
    logic [DATA_W-1:0] data_b_i = '0;
    logic              gnt_a_o, gnt_b_o, busy_o;
    logic [DATA_W-1:0] display_o;

    always #5 clk = ~clk;

    module_display_arbiter #(
        .DATA_W    (DATA_W),
        .HOLD_TICKS(HOLD),
        .HOLD_BITS (HB)
    ) dut (
        .clk_10Mhz_i(clk),
        .reset_i    (reset_i),
        .tick_i     (tick_i),
        .req_a_i    (req_a_i),
        .data_a_i   (data_a_i),
        .req_b_i    (req_b_i),
        .data_b_i   (data_b_i),
        .gnt_a_o    (gnt_a_o),
        .gnt_b_o    (gnt_b_o),
        .display_o  (display_o),
        .busy_o     (busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: owner 0 = nobody, 1 = A, 2 = B; held = ticks counted since the grant.
    int          m_owner = 0;
    int          m_held  = 0;
    int          m_pref  = 1;
    logic [31:0] m_disp  = '0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin : model
        logic        req [1:2];
        logic [31:0] dat [1:2];
        int          win;
        int          other;
        req[1] = req_a_i;  req[2] = req_b_i;
        dat[1] = data_a_i; dat[2] = data_b_i;
        win = 0;
        if (reset_i) begin
            m_owner = 0; m_held = 0; m_pref = 1; m_disp = '0;
        end else if (m_owner == 0) begin
            if (req[1] && req[2]) win = m_pref;
            else if (req[1])      win = 1;
            else if (req[2])      win = 2;
            if (win != 0) begin
                m_owner = win; m_held = 0; m_disp = dat[win];
            end
        end else begin
            other = 3 - m_owner;
            if (!req[m_owner]) begin
                m_pref = other; m_owner = 0; m_held = 0;
            end else if (m_held == HOLD && req[other]) begin
                m_pref = m_owner; m_owner = other; m_held = 0; m_disp = dat[other];
            end else begin
                m_disp = dat[m_owner];
                if (tick_i && m_held < HOLD) m_held++;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_gnt_a", gnt_a_o, m_owner == 1);
        chk("model_gnt_b", gnt_b_o, m_owner == 2);
        chk("model_busy", busy_o, m_owner != 0);
        chkw("model_display", display_o, m_disp);
        chk("grant_exclusive", gnt_a_o & gnt_b_o, 1'b0);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            tick_i = (cyc % 10 == 0);
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        while (!tick_i && k < 25) begin
            step();
            k++;
        end
        if (!tick_i) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: no tick within 25 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        int   sw;
        int   prev;
        logic dropped_a;

        // Reset with both requests high, then A wins the first tie.
        reset_i = 1'b1; req_a_i = 1'b1; req_b_i = 1'b1;
        data_a_i = 32'hA5A5_0001; data_b_i = 32'h5A5A_0002;
        step(3);
        chk("rst_gnt_a", gnt_a_o, 1'b0);
        chk("rst_gnt_b", gnt_b_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chkw("rst_display", display_o, 32'h0);
        reset_i = 1'b0;
        step();
        chk("first_gnt_a", gnt_a_o, 1'b1);
        chk("first_gnt_b", gnt_b_o, 1'b0);
        chkw("first_display", display_o, 32'hA5A5_0001);

        // Single source B.
        req_a_i = 1'b0; req_b_i = 1'b0;
        step();
        chk("idle_busy", busy_o, 1'b0);
        chkw("idle_display_hold", display_o, 32'hA5A5_0001);
        data_b_i = 32'hDEAD_BEEF; req_b_i = 1'b1;
        step();
        chk("single_gnt_b", gnt_b_o, 1'b1);
        chkw("single_display", display_o, 32'hDEAD_BEEF);
        req_b_i = 1'b0;
        step();
        chk("single_drop_gnt_b", gnt_b_o, 1'b0);
        chkw("single_drop_display", display_o, 32'hDEAD_BEEF);

        // Contention: B asserts on tick 1 of A's grant, swaps the cycle after tick 4.
        data_a_i = 32'h1111_0000; req_a_i = 1'b1;
        step();
        chk("cont_gnt_a", gnt_a_o, 1'b1);
        wait_tick();
        data_b_i = 32'h2222_0000; req_b_i = 1'b1;
        step(31);
        chk("cont_hold_a", gnt_a_o, 1'b1);
        chk("cont_hold_b", gnt_b_o, 1'b0);
        step();
        chk("cont_swap_b", gnt_b_o, 1'b1);
        chk("cont_swap_a", gnt_a_o, 1'b0);
        chkw("cont_swap_display", display_o, 32'h2222_0000);

        // Fairness: both held for 40 ticks, owner alternates every 4 ticks.
        sw = 0;
        prev = 2;
        repeat (400) begin
            step();
            if (gnt_a_o && prev == 2) begin sw++; prev = 1; end
            if (gnt_b_o && prev == 1) begin sw++; prev = 2; end
        end
        chk("fair_switch_count", sw inside {[9:10]}, 1'b1);

        // Owner drop coincident with a tick: IDLE first, then the other side.
        wait_tick();
        dropped_a = (m_owner == 1);
        if (dropped_a) req_a_i = 1'b0;
        else           req_b_i = 1'b0;
        step();
        chk("drop_idle_busy", busy_o, 1'b0);
        chk("drop_idle_gnt_a", gnt_a_o, 1'b0);
        chk("drop_idle_gnt_b", gnt_b_o, 1'b0);
        step();
        chk("drop_regrant", dropped_a ? gnt_b_o : gnt_a_o, 1'b1);
        req_a_i = 1'b1; req_b_i = 1'b1;
        step(50);

        // Saturated hold: a late request from B switches one cycle after it asserts.
        req_b_i = 1'b0; req_a_i = 1'b1;
        step(2);
        chk("sat_own_a", gnt_a_o, 1'b1);
        step(60);
        data_b_i = 32'h3333_0000; req_b_i = 1'b1;
        step();
        chk("sat_switch_b", gnt_b_o, 1'b1);
        chkw("sat_switch_display", display_o, 32'h3333_0000);

        // Reset pulse while B owns, then A wins with both requesting.
        step(3);
        chk("pre_reset_gnt_b", gnt_b_o, 1'b1);
        reset_i = 1'b1;
        step();
        chk("midrst_gnt_b", gnt_b_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chkw("midrst_display", display_o, 32'h0);
        reset_i = 1'b0;
        step();
        chk("post_rst_gnt_a", gnt_a_o, 1'b1);
        chkw("post_rst_display", display_o, 32'h1111_0000);
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
